attopu_exec: RTL and testbench

- Execute stage of the attoPU datapath. Sits directly upstream of the register file write-back port.
- Consumes the two register-file read operands plus a decoded op, destination and valid strobe. Produces a write-back triple that wires straight to the register file's data, select and enable inputs.
- ALU ops complete in one cycle. MUL is a multi-cycle shift-add. A ready/valid handshake stalls the decoder while MUL runs.

---
 rtl/attopu_exec_pkg.sv | 23 ++
 rtl/attopu_exec_if.sv | 27 ++
 rtl/attopu_exec_mul_seq.sv | 65 ++++++
 rtl/attopu_exec.sv | 131 +++++++++++++
 tb/tb_attopu_exec.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/attopu_exec_pkg.sv
// Shared definitions for the attoPU execute stage: op codes, default widths and FSM states.
package attopu_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SEL_W_DEF = 2;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/attopu_exec_if.sv
// Decoder-to-execute request bundle plus the write-back/flag outputs toward the register file.
interface attopu_exec_if #(
    parameter int WIDTH = attopu_pkg::WIDTH_DEF,
    parameter int SEL_W = attopu_pkg::SEL_W_DEF
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [SEL_W-1:0] dst;
    logic [WIDTH-1:0] wb_data;
    logic [SEL_W-1:0] wb_sel;
    logic             wb_en;
    logic             flag_z;
    logic             flag_c;

    modport master (
        output in_valid, op, op_a, op_b, dst,
        input  in_ready, wb_data, wb_sel, wb_en, flag_z, flag_c
    );

    modport slave (
        input  in_valid, op, op_a, op_b, dst,
        output in_ready, wb_data, wb_sel, wb_en, flag_z, flag_c
    );
endinterface

// File: rtl/attopu_exec_mul_seq.sv
// Unsigned shift-add multiplier: one partial product per cycle, done pulses once after WIDTH iterations.
module attopu_mul_seq
    import attopu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d, addend;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d;

    assign addend = {{WIDTH{1'b0}}, a_q} << cnt_q;

    always_comb begin
        acc_d  = acc_q;
        a_d    = a_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            a_d    = a;
            b_d    = b;
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (b_q[cnt_q]) acc_d = acc_q + addend;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Only control is reset; a reset mid-run simply drops the accumulator contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
        end
        acc_q <= acc_d;
        a_q   <= a_d;
        b_q   <= b_d;
        cnt_q <= cnt_d;
    end

    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/attopu_exec.sv
// attoPU execute stage: single-cycle ALU inline, sequential MUL, registered write-back triple and flags.
module attopu_exec
    import attopu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    attopu_exec_if.slave  bus
);
    localparam int SH_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   wb_data_q, wb_data_d;
    logic [SEL_W-1:0]   wb_sel_q, wb_sel_d, dst_q, dst_d;
    logic               wb_en_q, wb_en_d, flag_z_q, flag_z_d, flag_c_q, flag_c_d;

    logic               accept, mul_start, mul_done;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] shl_w, shr_w;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    op_e                op;

    assign op        = op_e'(bus.op);
    assign accept    = bus.in_valid && (state_q == ST_IDLE);
    assign mul_start = accept && (op == OP_MUL);

    attopu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.op_a),
        .b       (bus.op_b),
        .done    (mul_done),
        .product (product)
    );

    // Shifts run in a double-width window so the last bit shifted out lands at a fixed position.
    assign sum   = {1'b0, bus.op_a} + {1'b0, bus.op_b};
    assign shl_w = {{WIDTH{1'b0}}, bus.op_a} << bus.op_b[SH_W-1:0];
    assign shr_w = {bus.op_a, {WIDTH{1'b0}}} >> bus.op_b[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op)
            OP_ADD: {alu_c, alu_res} = sum;
            OP_SUB: begin
                alu_res = bus.op_a - bus.op_b;
                alu_c   = bus.op_a < bus.op_b;
            end
            OP_AND: alu_res = bus.op_a & bus.op_b;
            OP_OR:  alu_res = bus.op_a | bus.op_b;
            OP_XOR: alu_res = bus.op_a ^ bus.op_b;
            OP_SHL: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_w[2*WIDTH-1:WIDTH];
                alu_c   = shr_w[WIDTH-1];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wb_data_d = wb_data_q;
        wb_sel_d  = wb_sel_q;
        wb_en_d   = 1'b0;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        dst_d     = dst_q;
        case (state_q)
            ST_IDLE: begin
                if (mul_start) begin
                    dst_d   = bus.dst;
                    state_d = ST_MUL;
                end else if (accept) begin
                    wb_en_d   = 1'b1;
                    wb_data_d = alu_res;
                    wb_sel_d  = bus.dst;
                    flag_z_d  = (alu_res == '0);
                    flag_c_d  = alu_c;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d   = ST_IDLE;
                    wb_en_d   = 1'b1;
                    wb_data_d = product[WIDTH-1:0];
                    wb_sel_d  = dst_q;
                    flag_z_d  = (product[WIDTH-1:0] == '0);
                    flag_c_d  = |product[2*WIDTH-1:WIDTH];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            wb_data_q <= '0;
            wb_sel_q  <= '0;
            wb_en_q   <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_data_q <= wb_data_d;
            wb_sel_q  <= wb_sel_d;
            wb_en_q   <= wb_en_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
        end
        dst_q <= dst_d;
    end

    assign bus.in_ready = (state_q == ST_IDLE);
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_sel   = wb_sel_q;
    assign bus.wb_en    = wb_en_q;
    assign bus.flag_z   = flag_z_q;
    assign bus.flag_c   = flag_c_q;

endmodule

// File: tb/tb_attopu_exec.sv
// Directed bench for attopu_exec: hand-computed vectors for reset, ALU ops, shift edges, MUL and MUL abort.
module tb_attopu_exec;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   rdy_hi;
    int   en_hi;

    attopu_exec_if #(.WIDTH(16), .SEL_W(2)) bus ();

    attopu_exec #(.WIDTH(16), .SEL_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic [1:0] d);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.dst      = d;
    endtask

    task automatic wb_chk(input string tag, input logic [15:0] data, input logic [1:0] sel,
                          input logic z, input logic c);
        chk({tag, "_en"},   32'(bus.wb_en),   32'd1);
        chk({tag, "_data"}, 32'(bus.wb_data), 32'(data));
        chk({tag, "_sel"},  32'(bus.wb_sel),  32'(sel));
        chk({tag, "_z"},    32'(bus.flag_z),  32'(z));
        chk({tag, "_c"},    32'(bus.flag_c),  32'(c));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.op = 3'd0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.dst = '0;
        tick();
        tick();
        rst = 1'b1;
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_en",    32'(bus.wb_en),    32'd0);
        chk("rst_data",  32'(bus.wb_data),  32'd0);
        chk("rst_z",     32'(bus.flag_z),   32'd0);
        chk("rst_c",     32'(bus.flag_c),   32'd0);

        issue(3'd0, 16'hFFFF, 16'h0001, 2'd2);
        tick();
        wb_chk("add", 16'h0000, 2'd2, 1'b1, 1'b1);
        bus.in_valid = 1'b0;
        tick();
        chk("add_pulse", 32'(bus.wb_en), 32'd0);
        chk("add_hold_z", 32'(bus.flag_z), 32'd1);
        chk("add_hold_c", 32'(bus.flag_c), 32'd1);

        issue(3'd1, 16'd3, 16'd5, 2'd3);
        tick();
        wb_chk("sub", 16'hFFFE, 2'd3, 1'b0, 1'b1);
        chk("sub_ready", 32'(bus.in_ready), 32'd1);
        issue(3'd5, 16'h8001, 16'h0001, 2'd0);
        tick();
        wb_chk("shl", 16'h0002, 2'd0, 1'b0, 1'b1);
        chk("shl_ready", 32'(bus.in_ready), 32'd1);

        // Reset asserted while the decoder keeps presenting an op.
        issue(3'd0, 16'd1, 16'd1, 2'd1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst_en", 32'(bus.wb_en), 32'd0);
        end
        rst = 1'b1;
        bus.in_valid = 1'b0;
        chk("mrst_data",  32'(bus.wb_data),  32'd0);
        chk("mrst_z",     32'(bus.flag_z),   32'd0);
        chk("mrst_c",     32'(bus.flag_c),   32'd0);
        chk("mrst_ready", 32'(bus.in_ready), 32'd1);

        issue(3'd6, 16'h00F0, 16'h0010, 2'd1);
        tick();
        wb_chk("shr0", 16'h00F0, 2'd1, 1'b0, 1'b0);
        issue(3'd6, 16'h0003, 16'h0001, 2'd2);
        tick();
        wb_chk("shr1", 16'h0001, 2'd2, 1'b0, 1'b1);
        issue(3'd2, 16'hF0F0, 16'hFF00, 2'd3);
        tick();
        wb_chk("and", 16'hF000, 2'd3, 1'b0, 1'b0);
        issue(3'd3, 16'h00F0, 16'h0F00, 2'd0);
        tick();
        wb_chk("or", 16'h0FF0, 2'd0, 1'b0, 1'b0);
        issue(3'd4, 16'h1234, 16'h1234, 2'd1);
        tick();
        wb_chk("xor", 16'h0000, 2'd1, 1'b1, 1'b0);

        // MUL 300*300 with a competing op (and changed operands) held on the bus throughout.
        issue(3'd7, 16'd300, 16'd300, 2'd1);
        tick();
        chk("mul_acc_ready", 32'(bus.in_ready), 32'd0);
        issue(3'd0, 16'd1, 16'd1, 2'd3);
        rdy_hi = 0;
        en_hi = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (bus.in_ready) rdy_hi++;
            if (bus.wb_en) en_hi++;
        end
        chk("mul_busy_ready", 32'(rdy_hi), 32'd0);
        chk("mul_busy_en",    32'(en_hi),  32'd0);
        bus.in_valid = 1'b0;
        tick();
        wb_chk("mul", 16'h5F90, 2'd1, 1'b0, 1'b1);
        chk("mul_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("mul_pulse", 32'(bus.wb_en), 32'd0);

        issue(3'd7, 16'd3, 16'd5, 2'd2);
        tick();
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 16; k++) tick();
        chk("mul_small_early", 32'(bus.wb_en), 32'd0);
        tick();
        wb_chk("mul_small", 16'd15, 2'd2, 1'b0, 1'b0);

        // Abort a MUL partway through; nothing may ever be written back.
        issue(3'd7, 16'd300, 16'd300, 2'd3);
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        en_hi = 0;
        for (int k = 0; k < 24; k++) begin
            if (bus.wb_en) en_hi++;
            tick();
        end
        chk("abort_no_wb",  32'(en_hi),          32'd0);
        chk("abort_ready",  32'(bus.in_ready),   32'd1);
        issue(3'd0, 16'd2, 16'd2, 2'd2);
        tick();
        wb_chk("abort_add", 16'd4, 2'd2, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        chk("abort_add_pulse", 32'(bus.wb_en), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
